alu_issue_stage: RTL and testbench

- Upstream feeder for the 32-bit ALU.
- Accepts ALU commands (op, A, B, tag) over a valid/ready interface and buffers them in a command FIFO.
- Issues one command per cycle to the ALU operand/opcode inputs, tracks each command through the ALU's registered latency, and captures Result plus flags into an in-order response buffer with valid/ready output.
- Illegal opcodes are filtered at the input, so the ALU only ever sees encodings 0000..1000.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_sync_fifo.sv | 56 +++++
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 tb/tb_alu_issue_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, flag layout, and the
// command/response records carried through the FIFOs.
package alu_pkg;

   localparam int unsigned ALU_W     = 32;
   localparam int unsigned ALU_TAG_W = 4;

   typedef enum logic [3:0] {
      OP_ADD = 4'b0000,
      OP_SUB = 4'b0001,
      OP_AND = 4'b0010,
      OP_OR  = 4'b0011,
      OP_XOR = 4'b0100,
      OP_NOR = 4'b0101,
      OP_SLT = 4'b0110,
      OP_SLL = 4'b0111,
      OP_SRL = 4'b1000
   } alu_op_e;

   localparam logic [3:0] ALU_OP_MAX = 4'b1000;

   typedef struct packed {
      logic negative;
      logic overflow;
      logic carry;
      logic zero;
   } alu_flags_t;

   typedef struct packed {
      alu_op_e              op;
      logic [ALU_W-1:0]     a;
      logic [ALU_W-1:0]     b;
      logic [ALU_TAG_W-1:0] tag;
   } cmd_t;

   typedef struct packed {
      logic [ALU_W-1:0]     result;
      alu_flags_t           flags;
      logic [ALU_TAG_W-1:0] tag;
   } rsp_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= ALU_OP_MAX;
   endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with a phase bit per pointer; full/empty come from
// comparing the phase bits when the indices match. Storage clears on reset.
module alu_sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_idx, rd_idx;
   logic          wr_ph, rd_ph;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx <= '0;
         rd_idx <= '0;
         wr_ph  <= 1'b0;
         rd_ph  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_idx] <= wdata;
            if (wr_idx == LAST) begin
               wr_idx <= '0;
               wr_ph  <= ~wr_ph;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
         if (pop) begin
            if (rd_idx == LAST) begin
               rd_idx <= '0;
               rd_ph  <= ~rd_ph;
            end else begin
               rd_idx <= rd_idx + 1'b1;
            end
         end
      end
   end

   assign rdata = mem[rd_idx];
   assign empty = (wr_idx == rd_idx) && (wr_ph == rd_ph);
   assign full  = (wr_idx == rd_idx) && (wr_ph != rd_ph);

endmodule

// File: rtl/alu_issue_stage.sv
// Command FIFO -> ALU issue -> latency-matched capture -> in-order response
// buffer. Illegal opcodes are counted and dropped at the input.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned ALU_LAT   = 1,
   parameter int unsigned RSP_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_overflow,
   input  logic              alu_negative,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic [3:0]        rsp_flags,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [7:0]        illegal_cnt,
   output logic              busy
);

   localparam int unsigned OW = $clog2(RSP_DEPTH + 1);
   localparam logic [OW-1:0] RSP_SLOTS = OW'(RSP_DEPTH);

   cmd_t             cmd_in, cmd_head;
   rsp_t             rsp_in, rsp_head;
   logic             cmd_full, cmd_empty, cmd_push, accept;
   logic             rsp_full, rsp_empty, rsp_pop;
   logic             issue, capture;
   logic [OW-1:0]    outstanding;
   logic [ALU_LAT:0] pipe_v;
   logic [TAG_W-1:0] pipe_tag [ALU_LAT+1];

   assign cmd_ready = !cmd_full;
   assign accept    = cmd_valid && cmd_ready;
   assign cmd_push  = accept && op_is_legal(cmd_op);
   assign cmd_in    = '{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b, tag: cmd_tag};

   alu_sync_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk(clk), .rst(rst), .push(cmd_push), .wdata(cmd_in), .pop(issue),
      .rdata(cmd_head), .full(cmd_full), .empty(cmd_empty)
   );

   // outstanding = in-flight + buffered responses, so a slot is reserved at issue
   assign issue = !cmd_empty && !rsp_full && (outstanding < RSP_SLOTS);

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({issue, rsp_pop})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_op <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
      end else if (issue) begin
         alu_op <= cmd_head.op;
         alu_a  <= cmd_head.a;
         alu_b  <= cmd_head.b;
      end
   end

   // Tail of this shift register lines up with Result arriving from the ALU.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v <= '0;
         for (int unsigned i = 0; i <= ALU_LAT; i++) pipe_tag[i] <= '0;
      end else begin
         pipe_v[0]   <= issue;
         pipe_tag[0] <= cmd_head.tag;
         for (int unsigned i = 1; i <= ALU_LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   assign capture = pipe_v[ALU_LAT];
   assign rsp_in  = '{result: alu_result,
                      flags: '{negative: alu_negative, overflow: alu_overflow,
                               carry: alu_carry, zero: alu_zero},
                      tag: pipe_tag[ALU_LAT]};

   alu_sync_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk(clk), .rst(rst), .push(capture), .wdata(rsp_in), .pop(rsp_pop),
      .rdata(rsp_head), .full(rsp_full), .empty(rsp_empty)
   );

   assign rsp_valid  = !rsp_empty;
   assign rsp_pop    = rsp_valid && rsp_ready;
   assign rsp_result = rsp_head.result;
   assign rsp_flags  = rsp_head.flags;
   assign rsp_tag    = rsp_head.tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_cnt <= '0;
      end else if (accept && !op_is_legal(cmd_op) && illegal_cnt != 8'hFF) begin
         illegal_cnt <= illegal_cnt + 8'd1;
      end
   end

   assign busy = !cmd_empty || (|pipe_v) || !rsp_empty;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a one-stage registered ALU model
// feeding Result/flags back into the DUT.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a, cmd_b;
   logic [3:0]  cmd_tag;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b;
   logic [31:0] alu_result;
   logic        alu_zero, alu_carry, alu_overflow, alu_negative;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [3:0]  rsp_tag;
   logic [7:0]  illegal_cnt;
   logic        busy;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(
      .DATA_W(32), .TAG_W(4), .CMD_DEPTH(4), .ALU_LAT(1), .RSP_DEPTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_negative(alu_negative),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
      .illegal_cnt(illegal_cnt), .busy(busy)
   );

   // ALU model: returns {N,V,C,Z,Result}; SUB carry is the no-borrow carry of A+~B+1.
   function automatic logic [35:0] alu_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic c, v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~(a | b);
         4'd6: r = {31'd0, $signed(a) < $signed(b)};
         4'd7: r = a << b[4:0];
         4'd8: r = a >> b[4:0];
         default: r = '0;
      endcase
      return {r[31], v, c, (r == 32'd0), r};
   endfunction

   always @(posedge clk) begin
      logic [35:0] e;
      e = alu_eval(alu_op, alu_a, alu_b);
      {alu_negative, alu_overflow, alu_carry, alu_zero, alu_result} <= e;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      int unsigned n = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      if (!cmd_ready) begin
         vectors++; miscompares++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
      end else begin
         tick();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [31:0] r, output logic [3:0] f, output logic [3:0] t);
      int unsigned n = 0;
      rsp_ready = 1'b0;
      while (!rsp_valid && n < 50) begin tick(); n++; end
      if (!rsp_valid) begin
         vectors++; miscompares++;
         $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      end
      r = rsp_result; f = rsp_flags; t = rsp_tag;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [118:0] got;
      cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      got = {cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_flags, rsp_tag, illegal_cnt, busy};
      vectors++;
      if (got !== {1'b1, 118'd0}) begin
         miscompares++;
         $display("FAIL reset_values: got %h required %h", got, {1'b1, 118'd0});
      end
   endtask

   task automatic test_single_add();
      rsp_ready = 1'b1;
      push_cmd(4'd0, 32'd10, 32'd5, 4'd3);           // now just after E0
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL add_busy_e0: got %b required 1", busy); end
      tick();                                          // after E1: issued
      vectors++; if ({alu_a, alu_b} !== {32'd10, 32'd5}) begin miscompares++; $display("FAIL add_issue_operands: got %h required %h", {alu_a, alu_b}, {32'd10, 32'd5}); end
      tick();                                          // after E2
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_early_valid: got %b required 0", rsp_valid); end
      tick();                                          // after E3
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid_e3: got %b required 1", rsp_valid); end
      vectors++; if ({rsp_result, rsp_flags, rsp_tag} !== {32'd15, 4'b0000, 4'd3}) begin miscompares++; $display("FAIL add_response: got %h required %h", {rsp_result, rsp_flags, rsp_tag}, {32'd15, 4'b0000, 4'd3}); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL add_busy_e3: got %b required 1", busy); end
      tick();                                          // after E4: popped
      vectors++; if ({rsp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL add_after_pop: got %b required 00", {rsp_valid, busy}); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; logic [3:0] f, t;
      push_cmd(4'd0, 32'h7735_9400, 32'h5968_2F00, 4'd1);   //  2000000000 + 1500000000
      push_cmd(4'd1, 32'h88CA_6C00, 32'h3B9A_CA00, 4'd2);   // -2000000000 - 1000000000
      get_rsp(r, f, t);
      vectors++; if ({r, f, t} !== {32'hD09D_C300, 4'b1100, 4'd1}) begin miscompares++; $display("FAIL b2b_add: got %h required %h", {r, f, t}, {32'hD09D_C300, 4'b1100, 4'd1}); end
      get_rsp(r, f, t);
      vectors++; if ({r, f, t} !== {32'h4D2F_A200, 4'b0110, 4'd2}) begin miscompares++; $display("FAIL b2b_sub: got %h required %h", {r, f, t}, {32'h4D2F_A200, 4'b0110, 4'd2}); end
   endtask

   task automatic test_illegal();
      logic [31:0] r; logic [3:0] f, t;
      int unsigned extra = 0;
      push_cmd(4'd2, 32'hFF00_FF00, 32'h00FF_00FF, 4'd4);
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready_before: got %b required 1", cmd_ready); end
      push_cmd(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 4'd5);
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready_after: got %b required 1", cmd_ready); end
      vectors++; if (illegal_cnt !== 8'd1) begin miscompares++; $display("FAIL illegal_cnt_one: got %0d required 1", illegal_cnt); end
      push_cmd(4'd2, 32'hFF00_FF00, 32'h00FF_00FF, 4'd6);
      get_rsp(r, f, t);
      vectors++; if ({r, f, t} !== {32'd0, 4'b0001, 4'd4}) begin miscompares++; $display("FAIL illegal_and_first: got %h required %h", {r, f, t}, {32'd0, 4'b0001, 4'd4}); end
      get_rsp(r, f, t);
      vectors++; if ({r, f, t} !== {32'd0, 4'b0001, 4'd6}) begin miscompares++; $display("FAIL illegal_and_second: got %h required %h", {r, f, t}, {32'd0, 4'b0001, 4'd6}); end
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) extra++;
         tick();
      end
      vectors++; if (extra !== 0) begin miscompares++; $display("FAIL illegal_no_third_rsp: got %0d extra cycles valid required 0", extra); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL illegal_idle: got busy=%b required 0", busy); end
   endtask

   task automatic test_backpressure();
      logic [31:0] r; logic [3:0] f, t;
      logic [31:0] exp_r;
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_cmd(4'd7, 32'd1, 32'(i), 4'(i));
      tick(); tick(); tick();
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low: got %b required 0", cmd_ready); end
      vectors++; if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 32'd1, 4'd0}) begin miscompares++; $display("FAIL bp_head_stable: got %h required %h", {rsp_valid, rsp_result, rsp_tag}, {1'b1, 32'd1, 4'd0}); end
      for (int i = 0; i < 6; i++) begin
         get_rsp(r, f, t);
         exp_r = 32'd1 << i;
         vectors++;
         if ({r, f, t} !== {exp_r, 4'b0000, 4'(i)}) begin
            miscompares++;
            $display("FAIL bp_rsp_%0d: got %h required %h", i, {r, f, t}, {exp_r, 4'b0000, 4'(i)});
         end
      end
      tick(); tick(); tick();
      vectors++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin miscompares++; $display("FAIL bp_drained: got %b required 001", {rsp_valid, busy, cmd_ready}); end
   endtask

   task automatic test_reset_midflight();
      logic [118:0] got;
      logic [31:0] r; logic [3:0] f, t;
      int unsigned seen = 0;
      rsp_ready = 1'b0;
      push_cmd(4'd0, 32'd1, 32'd1, 4'd7);    // E0
      push_cmd(4'd0, 32'd2, 32'd2, 4'd8);    // E1: first issues
      cmd_op = 4'd0; cmd_a = 32'd3; cmd_b = 32'd3; cmd_tag = 4'd9; cmd_valid = 1'b1;
      rst = 1'b1;
      tick();                                 // E2: second's issue edge, reset wins
      rst = 1'b0; cmd_valid = 1'b0;
      got = {cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_flags, rsp_tag, illegal_cnt, busy};
      vectors++; if (got !== {1'b1, 118'd0}) begin miscompares++; $display("FAIL midreset_values: got %h required %h", got, {1'b1, 118'd0}); end
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid || busy) seen++;
         tick();
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midreset_flushed: got %0d active cycles required 0", seen); end
      push_cmd(4'd8, 32'h80, 32'd3, 4'd10);
      get_rsp(r, f, t);
      vectors++; if ({r, f, t} !== {32'd16, 4'b0000, 4'd10}) begin miscompares++; $display("FAIL midreset_srl: got %h required %h", {r, f, t}, {32'd16, 4'b0000, 4'd10}); end
   endtask

   task automatic test_saturation();
      vectors++; if (illegal_cnt !== 8'd0) begin miscompares++; $display("FAIL sat_start: got %0d required 0", illegal_cnt); end
      for (int i = 0; i < 254; i++) push_cmd(4'b1001 + 4'(i % 7), 32'd0, 32'd0, 4'd0);
      vectors++; if (illegal_cnt !== 8'd254) begin miscompares++; $display("FAIL sat_254: got %0d required 254", illegal_cnt); end
      push_cmd(4'b1111, 32'd0, 32'd0, 4'd0);
      vectors++; if (illegal_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_255: got %0d required 255", illegal_cnt); end
      for (int i = 0; i < 5; i++) push_cmd(4'b1100, 32'd0, 32'd0, 4'd0);
      tick(); tick();
      vectors++; if (illegal_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d required 255", illegal_cnt); end
      vectors++; if ({rsp_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL sat_no_rsp: got %b required 00", {rsp_valid, busy}); end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_reset_midflight();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
